// File: rtl/fifo_ctrl_if.sv
// Client-side handshake, status and error bundle for the FIFO controller.
// The DUT takes the slave view and the client takes the master view.
interface fifo_ctrl_if #(
  parameter int DW = 9,
  parameter int AW = 8
);
  logic          push;
  logic [DW-1:0] wdata;
  logic          pop;
  logic          flush;
  logic          err_clr;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport slave (
    input  push, wdata, pop, flush, err_clr,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport master (
    output push, wdata, pop, flush, err_clr,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller around an external 2**AW x DW dual-port memory
// with an asynchronous read port; the read data is registered here.
module fifo_ctrl #(
  parameter int DW       = 9,
  parameter int AW       = 8,
  parameter int AF_LEVEL = 252,
  parameter int AE_LEVEL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_ctrl_if.slave    bus,
  output logic [AW-1:0] mem_a1,
  output logic [DW-1:0] mem_wd1,
  output logic          mem_we1,
  output logic [AW-1:0] mem_a2,
  input  logic [DW-1:0] mem_rd2
);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_e;

  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_CNT    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_CNT    = AE_LEVEL[AW:0];
  localparam logic [AW:0] ZERO_CNT  = '0;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ok, pop_ok;

  // Holding reset or flush blocks both ports, so no memory write escapes either.
  assign pop_ok  = bus.pop & ~(state_q == S_EMPTY) & ~bus.flush & rst_n;
  assign push_ok = bus.push & (~(state_q == S_FULL) | pop_ok) & ~bus.flush & rst_n;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q & ~bus.err_clr;
    udf_d    = udf_q & ~bus.err_clr;

    if (bus.flush) begin
      state_d = S_EMPTY;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok) begin
        rptr_d   = rptr_q + AW'(1);
        rvalid_d = 1'b1;
        rdata_d  = mem_rd2;
      end
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      if (bus.push && !push_ok) ovf_d = 1'b1;
      if (bus.pop && !pop_ok)   udf_d = 1'b1;

      unique case (state_q)
        S_EMPTY:   if (push_ok) state_d = S_PARTIAL;
        S_PARTIAL: begin
          if (count_d == DEPTH_CNT)     state_d = S_FULL;
          else if (count_d == ZERO_CNT) state_d = S_EMPTY;
        end
        S_FULL:    if (pop_ok && !push_ok) state_d = S_PARTIAL;
        default:   state_d = S_EMPTY;
      endcase
    end

    af_d = (count_d >= AF_CNT);
    ae_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.full         = (state_q == S_FULL);
  assign bus.empty        = (state_q == S_EMPTY);
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  assign mem_a1  = wptr_q;
  assign mem_wd1 = bus.wdata;
  assign mem_we1 = push_ok;
  assign mem_a2  = rptr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 256 x 9 memory that has
// an asynchronous read port.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_a1, mem_a2;
  logic [8:0] mem_wd1, mem_rd2;
  logic       mem_we1;
  logic [8:0] mem [256];
  int         checks = 0;
  int         errors = 0;

  fifo_ctrl_if #(.DW(9), .AW(8)) bus ();

  fifo_ctrl #(.DW(9), .AW(8), .AF_LEVEL(252), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_a1(mem_a1), .mem_wd1(mem_wd1), .mem_we1(mem_we1),
    .mem_a2(mem_a2), .mem_rd2(mem_rd2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we1) mem[mem_a1] <= mem_wd1;
  assign mem_rd2 = mem[mem_a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic do_push(input logic [8:0] d);
    bus.push = 1'b1; bus.wdata = d;
    tick();
    idle();
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_count"}, 32'(bus.count), 0);
    chk({pfx, "_empty"}, 32'(bus.empty), 1);
    chk({pfx, "_full"}, 32'(bus.full), 0);
    chk({pfx, "_ae"}, 32'(bus.almost_empty), 1);
    chk({pfx, "_af"}, 32'(bus.almost_full), 0);
    chk({pfx, "_rvalid"}, 32'(bus.rvalid), 0);
    chk({pfx, "_rdata"}, 32'(bus.rdata), 0);
    chk({pfx, "_ovf"}, 32'(bus.overflow), 0);
    chk({pfx, "_udf"}, 32'(bus.underflow), 0);
    chk({pfx, "_a1"}, 32'(mem_a1), 0);
    chk({pfx, "_a2"}, 32'(mem_a2), 0);
  endtask

  initial begin
    logic [8:0] vec [3];
    vec[0] = 9'h1A5; vec[1] = 9'h003; vec[2] = 9'h0FF;
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;

    // Three pushes, three pops
    for (int i = 0; i < 3; i++) begin
      do_push(vec[i]);
      chk("push3_count", 32'(bus.count), 32'(i + 1));
    end
    chk("push3_empty", 32'(bus.empty), 0);
    for (int i = 0; i < 3; i++) begin
      bus.pop = 1'b1;
      tick();
      idle();
      $display("pop %0d: rdata=0x%03h rvalid=%0d count=%0d", i, bus.rdata, bus.rvalid, bus.count);
      chk("pop3_rvalid", 32'(bus.rvalid), 1);
      chk("pop3_rdata", 32'(bus.rdata), 32'(vec[i]));
      chk("pop3_count", 32'(bus.count), 32'(2 - i));
    end
    chk("pop3_empty", 32'(bus.empty), 1);
    tick();
    chk("pop3_rvalid_drop", 32'(bus.rvalid), 0);

    // Fill to 256 with value = index
    for (int i = 0; i < 256; i++) begin
      do_push(9'(i));
      if (i == 3)   chk("fill_ae_at4", 32'(bus.almost_empty), 1);
      if (i == 4)   chk("fill_ae_at5", 32'(bus.almost_empty), 0);
      if (i == 250) chk("fill_af_at251", 32'(bus.almost_full), 0);
      if (i == 251) chk("fill_af_at252", 32'(bus.almost_full), 1);
      if (i == 254) chk("fill_full_at255", 32'(bus.full), 0);
    end
    $display("filled: count=%0d full=%0d af=%0d", bus.count, bus.full, bus.almost_full);
    chk("fill_count", 32'(bus.count), 256);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_wptr_wrap", 32'(mem_a1), 3);

    // 257th push is rejected
    bus.push = 1'b1; bus.wdata = 9'h111;
    #1;
    chk("ovf_we1", 32'(mem_we1), 0);
    tick();
    idle();
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 256);

    // Push and pop together while full
    bus.push = 1'b1; bus.wdata = 9'h1FF; bus.pop = 1'b1;
    #1;
    chk("fullpp_we1", 32'(mem_we1), 1);
    tick();
    idle();
    chk("fullpp_rdata", 32'(bus.rdata), 0);
    chk("fullpp_count", 32'(bus.count), 256);
    chk("fullpp_full", 32'(bus.full), 1);

    // Drain everything
    for (int i = 0; i < 256; i++) begin
      bus.pop = 1'b1;
      tick();
      idle();
      chk("drain_rdata", 32'(bus.rdata), (i == 255) ? 32'h1FF : 32'(i + 1));
      if (i == 0) chk("drain_full_drop", 32'(bus.full), 0);
    end
    $display("drained: count=%0d empty=%0d last=0x%03h", bus.count, bus.empty, bus.rdata);
    chk("drain_count", 32'(bus.count), 0);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_rptr_wrap", 32'(mem_a2), 4);

    bus.err_clr = 1'b1;
    tick();
    idle();
    chk("errclr_ovf", 32'(bus.overflow), 0);

    // Pop on empty with concurrent push
    bus.pop = 1'b1; bus.push = 1'b1; bus.wdata = 9'h055;
    tick();
    idle();
    chk("emptypp_udf", 32'(bus.underflow), 1);
    chk("emptypp_rvalid", 32'(bus.rvalid), 0);
    chk("emptypp_count", 32'(bus.count), 1);
    bus.pop = 1'b1;
    tick();
    idle();
    chk("emptypp_rdata", 32'(bus.rdata), 32'h055);
    chk("emptypp_rvalid2", 32'(bus.rvalid), 1);

    // Fill 10 then flush with push/pop asserted
    for (int i = 0; i < 10; i++) do_push(9'(i + 16));
    chk("flush_pre_count", 32'(bus.count), 10);
    bus.flush = 1'b1; bus.push = 1'b1; bus.pop = 1'b1; bus.wdata = 9'h0AA;
    #1;
    chk("flush_we1", 32'(mem_we1), 0);
    tick();
    idle();
    $display("flush: count=%0d empty=%0d rvalid=%0d", bus.count, bus.empty, bus.rvalid);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_rvalid", 32'(bus.rvalid), 0);
    chk("flush_ovf", 32'(bus.overflow), 0);
    chk("flush_udf_kept", 32'(bus.underflow), 1);
    chk("flush_ptrs", 32'({mem_a1, mem_a2}), 0);

    // Set event beats err_clr
    bus.err_clr = 1'b1; bus.pop = 1'b1;
    tick();
    idle();
    chk("clrset_udf", 32'(bus.underflow), 1);
    bus.err_clr = 1'b1;
    tick();
    idle();
    chk("clr_udf", 32'(bus.underflow), 0);

    // Reset mid-operation with push held high
    for (int i = 0; i < 100; i++) do_push(9'(i + 1));
    chk("prerst_count", 32'(bus.count), 100);
    bus.pop = 1'b1;
    tick();
    idle();
    chk("prerst_rdata", 32'(bus.rdata), 1);
    rst_n = 1'b0; bus.push = 1'b1; bus.wdata = 9'h0F0;
    #1;
    chk("rst_we1", 32'(mem_we1), 0);
    tick();
    chk("rst_we1_hold", 32'(mem_we1), 0);
    chk_reset("rst2");
    idle();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
